mult_share_arbiter: RTL and testbench
=====================================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter WIDTH_X, default 10: unsigned sample operand width.
REQ-003 SHALL have parameter WIDTH_A, default 4: unsigned coefficient operand width.
REQ-004 SHALL have parameter LATENCY, default 1: multiplier pipeline depth in cycles (1..4).
REQ-005 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester operand-valid; held high until acked.
REQ-008 SHALL have port x_in  input  NUM_REQ*WIDTH_X  packed samples; requester i at [i*WIDTH_X +: WIDTH_X].
REQ-009 SHALL have port a_in  input  NUM_REQ*WIDTH_A  packed coefficients; requester i at [i*WIDTH_A +: WIDTH_A].
REQ-010 SHALL have port ack  output  NUM_REQ  one-hot (or zero) registered grant; operands consumed this cycle.
REQ-011 SHALL have port mul_x  output  WIDTH_X  operand x driven to shared multiplier.
REQ-012 SHALL have port mul_a  output  WIDTH_A  operand a driven to shared multiplier.
REQ-013 SHALL have port mul_y  input  WIDTH_X+WIDTH_A+1  signed product from multiplier, LATENCY cycles after operands.
REQ-014 SHALL have port res  output  WIDTH_X+WIDTH_A+1  signed result, copy of mul_y when res_valid.
REQ-015 SHALL have port res_valid  output  1  res/res_id valid this cycle.
REQ-016 SHALL have port res_id  output  clog2(NUM_REQ)  index of requester owning res.

Function
REQ-017 SHALL grant at most one requester per cycle, round-robin: search starts at index (last_grant+1) mod NUM_REQ, ascending with wrap.
REQ-018 SHALL, after reset, treat last_grant as NUM_REQ-1 so requester 0 has highest priority.
REQ-019 SHALL register the grant: ack, mul_x, mul_a asserted in cycle N+1 for winner chosen from req sampled at edge N.
REQ-020 SHALL drive mul_x/mul_a from the granted requester during the ack cycle and hold last values otherwise (no toggling when idle).
REQ-021 SHALL exclude a requester from arbitration in the cycle its ack is high (req still high then is its next operand, eligible next cycle).
REQ-022 SHALL update last_grant only on an actual grant; all-zero req leaves pointer unchanged.
REQ-023 SHALL carry issue-valid and requester id through a LATENCY-deep shift register aligned to the multiplier pipeline.
REQ-024 SHALL assert res_valid, res_id, res registered one cycle after mul_y becomes valid: total req-to-res_valid latency LATENCY+2 cycles when uncontended.
REQ-025 SHALL present results strictly in issue order; one result per issue, none dropped or duplicated.
REQ-026 SHALL sustain one issue per cycle with all requesters continuously requesting (back-to-back, no bubbles).
REQ-027 SHALL hold res at its last value when res_valid is low.
REQ-028 SHALL not interpret operands beyond passing them; sign/width extension is owned by the multiplier.

Reset
REQ-029 SHALL on reset clear ack, res_valid, res, res_id, mul_x, mul_a to 0 and clear the valid/id shift register.
REQ-030 SHALL discard all in-flight results when reset asserts mid-operation; first res_valid after reset only from a post-reset grant.
REQ-031 SHALL ignore req during reset cycles; first grant no earlier than the cycle after reset deasserts.

Verification
REQ-032 Single: LATENCY=1, req=0100, x_in[2]=1023, a_in[2]=15 -> ack=0100 one cycle later, res_valid with res=15345, res_id=2 three cycles after req.
REQ-033 Contention: req=1111 held, all accepted -> ack sequence 0001,0010,0100,1000,0001; res_id sequence 0,1,2,3,0 with no gaps.
REQ-034 Wrap/pointer: grant 3, then req=1001 -> next grant 0 (not 3); then req=1001 -> grant 3.
REQ-035 Idle hold: req=0 for 10 cycles after traffic -> ack=0, res_valid=0, mul_x/mul_a/res unchanged, pointer unchanged.
REQ-036 Reset mid-flight: LATENCY=3, issue 3 back-to-back ops, assert reset 1 cycle later -> no res_valid after reset; next req=0010 grants requester 1 normally.
REQ-037 Zero operand: x_in[1]=0, a_in[1]=9 -> res=0, res_valid=1, res_id=1.

Source files
------------

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_share_arbiter
//  Purpose  : Round-robin sharing of one external multiplier among NUM_REQ
//             requesters. Grants are registered, operands are muxed onto the
//             multiplier, and a LATENCY-deep valid/id pipeline tags each
//             product so results come back in issue order with their owner.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH_X = 10,
  parameter int WIDTH_A = 4,
  parameter int LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*WIDTH_X-1:0]      x_in,
  input  logic [NUM_REQ*WIDTH_A-1:0]      a_in,
  output logic [NUM_REQ-1:0]              ack,
  output logic [WIDTH_X-1:0]              mul_x,
  output logic [WIDTH_A-1:0]              mul_a,
  input  logic [WIDTH_X+WIDTH_A:0]        mul_y,
  output logic [WIDTH_X+WIDTH_A:0]        res,
  output logic                            res_valid,
  output logic [$clog2(NUM_REQ)-1:0]      res_id
);

  localparam int c_id_w = $clog2(NUM_REQ);
  localparam int c_y_w  = WIDTH_X + WIDTH_A + 1;
  // Pointer value that makes requester 0 the first candidate after reset.
  localparam logic [c_id_w-1:0] c_last_rst = c_id_w'(NUM_REQ - 1);

  // Arbitration state and registered grant.
  logic [c_id_w-1:0]  r_last;
  logic [NUM_REQ-1:0] r_ack;
  logic [c_id_w-1:0]  r_ack_id;
  logic [WIDTH_X-1:0] r_mul_x;
  logic [WIDTH_A-1:0] r_mul_a;

  // Issue tags travelling alongside the multiplier pipeline.
  logic [LATENCY-1:0] r_pipe_vld;
  logic [c_id_w-1:0]  r_pipe_id [LATENCY];

  // Result stage.
  logic               r_res_valid;
  logic [c_y_w-1:0]   r_res;
  logic [c_id_w-1:0]  r_res_id;

  // Combinational arbitration results.
  logic [NUM_REQ-1:0] w_elig;
  logic               w_grant_vld;
  logic [c_id_w-1:0]  w_grant_id;
  logic [NUM_REQ-1:0] w_grant_onehot;

  // Round-robin search starting just after the last winner; a requester
  // whose ack is high this cycle is presenting its next operand and must wait.
  always_comb begin
    w_elig         = req & ~r_ack;
    w_grant_vld    = 1'b0;
    w_grant_id     = '0;
    w_grant_onehot = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int                idx;
      logic [c_id_w-1:0] sel;
      idx = (int'(r_last) + k) % NUM_REQ;
      sel = idx[c_id_w-1:0];
      if (!w_grant_vld && w_elig[sel]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = sel;
      end
    end
    if (w_grant_vld) begin
      w_grant_onehot[w_grant_id] = 1'b1;
    end
  end

  // Register the grant and capture the winner's operands; operands and
  // pointer are held when nobody wins so the multiplier inputs stay quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack    <= '0;
      r_ack_id <= '0;
      r_last   <= c_last_rst;
      r_mul_x  <= '0;
      r_mul_a  <= '0;
    end else begin
      r_ack <= w_grant_onehot;
      if (w_grant_vld) begin
        r_ack_id <= w_grant_id;
        r_last   <= w_grant_id;
        r_mul_x  <= x_in[w_grant_id*WIDTH_X +: WIDTH_X];
        r_mul_a  <= a_in[w_grant_id*WIDTH_A +: WIDTH_A];
      end
    end
  end

  // Shift issue-valid and owner id so they line up with mul_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_pipe_id[k] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= |r_ack;
      r_pipe_id[0]  <= r_ack_id;
      for (int k = 1; k < LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_id[k]  <= r_pipe_id[k-1];
      end
    end
  end

  // Capture the product when its tag arrives; hold the last result otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res       <= '0;
      r_res_id    <= '0;
    end else begin
      r_res_valid <= r_pipe_vld[LATENCY-1];
      if (r_pipe_vld[LATENCY-1]) begin
        r_res    <= mul_y;
        r_res_id <= r_pipe_id[LATENCY-1];
      end
    end
  end

  assign ack       = r_ack;
  assign mul_x     = r_mul_x;
  assign mul_a     = r_mul_a;
  assign res       = r_res;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_share_arbiter
//  Purpose  : Self-checking bench for mult_share_arbiter, LATENCY 1 and 3
//             instances driven with the same requests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

  localparam int NR = 4;
  localparam int WX = 10;
  localparam int WA = 4;
  localparam int WY = WX + WA + 1;
  localparam int IW = $clog2(NR);

  typedef struct {
    int id;
    int prod;
    int due;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*WX-1:0] x_in;
  logic [NR*WA-1:0] a_in;

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check_val(input string tag, input int lat,
                           input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (LATENCY=%0d): got %0d expected %0d", tag, lat, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 1 : 3;

    logic [NR-1:0] ack;
    logic [WX-1:0] mul_x;
    logic [WA-1:0] mul_a;
    logic [WY-1:0] mul_y;
    logic [WY-1:0] res;
    logic          res_valid;
    logic [IW-1:0] res_id;
    logic [WY-1:0] mp [L];

    exp_t          q[$];
    exp_t          e;
    int            cyc;
    int            m_last;
    logic [NR-1:0] m_ack;
    logic [NR-1:0] elig;
    logic [WX-1:0] m_mx;
    logic [WA-1:0] m_ma;
    logic [WY-1:0] m_res;
    bit            gv;
    int            gid;
    bit            exp_v;

    mult_share_arbiter #(
      .NUM_REQ(NR), .WIDTH_X(WX), .WIDTH_A(WA), .LATENCY(L)
    ) u_dut (
      .clk(clk), .reset(reset), .req(req), .x_in(x_in), .a_in(a_in),
      .ack(ack), .mul_x(mul_x), .mul_a(mul_a), .mul_y(mul_y),
      .res(res), .res_valid(res_valid), .res_id(res_id)
    );

    // Behavioural multiplier with L-cycle pipeline.
    always @(posedge clk) begin
      mp[0] <= WY'(mul_x) * WY'(mul_a);
      for (int k = 1; k < L; k++) mp[k] <= mp[k-1];
    end
    assign mul_y = mp[L-1];

    // Reference arbiter model at the edge, then compare 1 time unit later.
    always @(posedge clk) begin
      cyc++;
      if (reset) begin
        q.delete();
        m_last = NR - 1;
        m_ack  = '0;
        m_mx   = '0;
        m_ma   = '0;
        m_res  = '0;
      end else begin
        elig = req & ~m_ack;
        gv   = 1'b0;
        gid  = 0;
        for (int k = 1; k <= NR; k++) begin
          int idx;
          idx = (m_last + k) % NR;
          if (!gv && elig[idx]) begin
            gv  = 1'b1;
            gid = idx;
          end
        end
        m_ack = '0;
        if (gv) begin
          m_ack[gid] = 1'b1;
          m_last     = gid;
          m_mx       = x_in[gid*WX +: WX];
          m_ma       = a_in[gid*WA +: WA];
          q.push_back('{id: gid, prod: int'(m_mx) * int'(m_ma), due: cyc + L + 1});
        end
      end
      #1;
      check_val("ack", L, 32'(ack), 32'(m_ack));
      check_val("mul_x", L, 32'(mul_x), 32'(m_mx));
      check_val("mul_a", L, 32'(mul_a), 32'(m_ma));
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check_val("res_valid", L, 32'(res_valid), 32'(exp_v));
      if (exp_v) begin
        e     = q.pop_front();
        m_res = WY'(e.prod);
        check_val("res_id", L, 32'(res_id), 32'(e.id));
        check_val("res", L, 32'(res), 32'(e.prod));
      end else begin
        check_val("res_hold", L, 32'(res), 32'(m_res));
      end
    end
  end

  // Drive n cycles of request/reset at the falling edge.
  task automatic step(input logic [NR-1:0] r, input logic rst, input int n, input bit rnd);
    repeat (n) begin
      @(negedge clk);
      reset = rst;
      req   = r;
      if (rnd) begin
        for (int i = 0; i < NR; i++) begin
          x_in[i*WX +: WX] = WX'($urandom);
          a_in[i*WA +: WA] = WA'($urandom);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    req     = '0;
    x_in    = '0;
    a_in    = '0;

    // Requests during reset must be ignored.
    step(4'b1111, 1'b1, 3, 1'b1);
    step(4'b0000, 1'b0, 2, 1'b0);

    // Single request: 1023 * 15 = 15345 from requester 2.
    x_in[2*WX +: WX] = 10'd1023;
    a_in[2*WA +: WA] = 4'd15;
    step(4'b0100, 1'b0, 1, 1'b0);
    step(4'b0000, 1'b0, 6, 1'b0);

    // Full contention, back-to-back.
    step(4'b1111, 1'b0, 9, 1'b1);
    step(4'b0000, 1'b0, 6, 1'b0);

    // Pointer wrap: grant 3, then 1001 -> 0, then 1001 -> 3.
    step(4'b1000, 1'b0, 1, 1'b1);
    step(4'b0000, 1'b0, 1, 1'b0);
    step(4'b1001, 1'b0, 1, 1'b1);
    step(4'b0000, 1'b0, 1, 1'b0);
    step(4'b1001, 1'b0, 1, 1'b1);
    step(4'b0000, 1'b0, 6, 1'b0);

    // Idle hold.
    step(4'b0000, 1'b0, 10, 1'b1);

    // Zero operand from requester 1.
    x_in[1*WX +: WX] = 10'd0;
    a_in[1*WA +: WA] = 4'd9;
    step(4'b0010, 1'b0, 1, 1'b0);
    step(4'b0000, 1'b0, 6, 1'b0);

    // Reset while results are in flight, then a normal request.
    step(4'b1111, 1'b0, 3, 1'b1);
    step(4'b0000, 1'b0, 1, 1'b1);
    step(4'b0000, 1'b1, 2, 1'b1);
    step(4'b0000, 1'b0, 1, 1'b1);
    step(4'b0010, 1'b0, 1, 1'b1);
    step(4'b0000, 1'b0, 8, 1'b0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      step(NR'($urandom), 1'b0, 1, 1'b1);
    end
    step(4'b0000, 1'b0, 12, 1'b1);

    @(negedge clk);
    check_val("drain_q", 1, 32'(g_inst[0].q.size()), 32'd0);
    check_val("drain_q", 3, 32'(g_inst[1].q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
